// File: rtl/lcd1602_pkg.sv
// Shared definitions for the HD44780/LCD1602 bus blocks: state encoding, bus timing
// in 50 MHz clock cycles, and register-select codes.
package lcd1602_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_EN_HIGH = 3'd2,
        ST_HOLD    = 3'd3,
        ST_GAP     = 3'd4,
        ST_DONE    = 3'd5
    } lcd_state_e;

    localparam int unsigned BF_BIT          = 7;
    localparam int unsigned LCD_SETUP_CYC   = 3;
    localparam int unsigned LCD_EN_HIGH_CYC = 25;
    localparam int unsigned LCD_HOLD_CYC    = 3;
    localparam int unsigned LCD_GAP_CYC     = 25;
    localparam int unsigned LCD_POLL_MAX    = 1000;

    localparam logic RS_CMD  = 1'b0;
    localparam logic RS_DATA = 1'b1;

    function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter; done_c is high during the last cycle of a loaded phase.
// A load of N (N >= 1) yields a phase of exactly N cycles.
module lcd_phase_timer #(
    parameter int unsigned W = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done_c
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val - W'(1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_c = (cnt_q == '0);

endmodule

// File: rtl/lcd_bus_reader.sv
// Read-side transactor for the LCD1602 8-bit bus: single busy-flag/data reads and
// busy-flag polling until BF clears or the poll budget runs out.
module lcd_bus_reader
    import lcd1602_pkg::*;
#(
    parameter int unsigned SETUP_CYC   = LCD_SETUP_CYC,
    parameter int unsigned EN_HIGH_CYC = LCD_EN_HIGH_CYC,
    parameter int unsigned HOLD_CYC    = LCD_HOLD_CYC,
    parameter int unsigned GAP_CYC     = LCD_GAP_CYC,
    parameter int unsigned POLL_MAX    = LCD_POLL_MAX
) (
    input  logic       clock_50mhz,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rs,
    input  logic       req_poll,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_busy,
    output logic [6:0] rsp_addr,
    output logic       rsp_timeout,
    output logic       bus_active,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic       lcd_data_oe,
    input  logic [7:0] lcd_data_in
);

    localparam int unsigned TW  = $clog2(max4(SETUP_CYC, EN_HIGH_CYC, HOLD_CYC, GAP_CYC) + 1);
    localparam int unsigned PCW = $clog2(POLL_MAX + 1);

    lcd_state_e     state_q, state_d;
    logic           rs_q, rs_d;
    logic           poll_q, poll_d;
    logic [PCW-1:0] rd_cnt_q, rd_cnt_d;
    logic [7:0]     rsp_data_q, rsp_data_d;
    logic           rsp_timeout_q, rsp_timeout_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic           req_ready_q, req_ready_d;
    logic           lcd_en_q, lcd_en_d;
    logic           lcd_rw_q, lcd_rw_d;
    logic           lcd_rs_q, lcd_rs_d;
    logic           lcd_oe_q, lcd_oe_d;
    logic           bus_active_q, bus_active_d;
    logic           ph_load;
    logic [TW-1:0]  ph_len;
    logic           ph_done_c;

    lcd_phase_timer #(.W(TW)) u_phase_timer (
        .clk      (clock_50mhz),
        .reset    (reset),
        .load     (ph_load),
        .load_val (ph_len),
        .done_c   (ph_done_c)
    );

    // Next state, capture registers and read counter.
    always_comb begin
        state_d       = state_q;
        rs_d          = rs_q;
        poll_d        = poll_q;
        rd_cnt_d      = rd_cnt_q;
        rsp_data_d    = rsp_data_q;
        rsp_timeout_d = rsp_timeout_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d  = ST_SETUP;
                    rs_d     = req_rs;
                    poll_d   = req_poll & (req_rs != RS_DATA);
                    rd_cnt_d = '0;
                end
            end
            ST_SETUP: begin
                if (ph_done_c) state_d = ST_EN_HIGH;
            end
            ST_EN_HIGH: begin
                if (ph_done_c) begin
                    state_d       = ST_HOLD;
                    rsp_data_d    = lcd_data_in;
                    rsp_timeout_d = 1'b0;
                    if (rd_cnt_q != PCW'(POLL_MAX)) rd_cnt_d = rd_cnt_q + PCW'(1);
                end
            end
            ST_HOLD: begin
                if (ph_done_c) begin
                    if (poll_q && rsp_data_q[BF_BIT] && (rd_cnt_q < PCW'(POLL_MAX))) begin
                        state_d = ST_GAP;
                    end else begin
                        state_d       = ST_DONE;
                        rsp_timeout_d = poll_q & rsp_data_q[BF_BIT];
                    end
                end
            end
            ST_GAP: begin
                if (ph_done_c) state_d = ST_EN_HIGH;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Phase timer reload and registered bus/handshake outputs decoded from the next state.
    always_comb begin
        ph_load      = (state_d != state_q);
        ph_len       = TW'(1);
        lcd_en_d     = 1'b0;
        lcd_rw_d     = 1'b0;
        lcd_rs_d     = RS_CMD;
        lcd_oe_d     = 1'b1;
        bus_active_d = 1'b0;
        rsp_valid_d  = 1'b0;
        req_ready_d  = 1'b0;
        case (state_d)
            ST_IDLE: req_ready_d = 1'b1;
            ST_SETUP, ST_EN_HIGH, ST_HOLD: begin
                lcd_rw_d     = 1'b1;
                lcd_rs_d     = rs_d;
                lcd_oe_d     = 1'b0;
                bus_active_d = 1'b1;
                lcd_en_d     = (state_d == ST_EN_HIGH);
                if (state_d == ST_SETUP)        ph_len = TW'(SETUP_CYC);
                else if (state_d == ST_EN_HIGH) ph_len = TW'(EN_HIGH_CYC);
                else                            ph_len = TW'(HOLD_CYC);
            end
            ST_GAP: begin
                lcd_rw_d     = 1'b1;
                lcd_oe_d     = 1'b0;
                bus_active_d = 1'b1;
                ph_len       = TW'(GAP_CYC);
            end
            ST_DONE: rsp_valid_d = 1'b1;
            default: req_ready_d = 1'b0;
        endcase
    end

    always_ff @(posedge clock_50mhz) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            rs_q          <= 1'b0;
            poll_q        <= 1'b0;
            rd_cnt_q      <= '0;
            rsp_data_q    <= '0;
            rsp_timeout_q <= 1'b0;
            rsp_valid_q   <= 1'b0;
            req_ready_q   <= 1'b1;
            lcd_en_q      <= 1'b0;
            lcd_rw_q      <= 1'b0;
            lcd_rs_q      <= 1'b0;
            lcd_oe_q      <= 1'b1;
            bus_active_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            rs_q          <= rs_d;
            poll_q        <= poll_d;
            rd_cnt_q      <= rd_cnt_d;
            rsp_data_q    <= rsp_data_d;
            rsp_timeout_q <= rsp_timeout_d;
            rsp_valid_q   <= rsp_valid_d;
            req_ready_q   <= req_ready_d;
            lcd_en_q      <= lcd_en_d;
            lcd_rw_q      <= lcd_rw_d;
            lcd_rs_q      <= lcd_rs_d;
            lcd_oe_q      <= lcd_oe_d;
            bus_active_q  <= bus_active_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_busy    = rsp_data_q[BF_BIT];
    assign rsp_addr    = rsp_data_q[6:0];
    assign rsp_timeout = rsp_timeout_q;
    assign bus_active  = bus_active_q;
    assign lcd_rs      = lcd_rs_q;
    assign lcd_rw      = lcd_rw_q;
    assign lcd_en      = lcd_en_q;
    assign lcd_data_oe = lcd_oe_q;

endmodule
